// File: rtl/wave_capture.sv
// Triggered audio capture into a double-buffered 512x8 wave RAM: waits for a rising zero
// crossing, writes 256 samples into the back half, then swaps halves when the display is idle.
// Optional WAVE_CAPTURE_AUTOTRIG_EN: force a trigger after 4096 strobes in ARMED.
module wave_capture (
   input  logic        clk,
   input  logic        reset,
   input  logic        new_sample_ready,
   input  logic [15:0] new_sample_in,
   input  logic        wave_display_idle,
   output logic [8:0]  write_address,
   output logic        write_enable,
   output logic [7:0]  write_sample,
   output logic        read_index
);

   localparam logic [1:0] ARMED  = 2'd0;
   localparam logic [1:0] ACTIVE = 2'd1;
   localparam logic [1:0] WAIT   = 2'd2;

   logic [1:0] r_state;
   logic [1:0] w_state_nxt;
   logic [7:0] r_count;
   logic       r_prev_msb;
   logic       r_read_index;
   logic       r_wr_en;
   logic [8:0] r_wr_addr;
   logic [7:0] r_wr_sample;

   logic       w_trig;
   logic       w_arm_fire;
   logic       w_wr_en;
   logic [7:0] w_wr_cnt;
   logic       w_prev_upd;
   logic       w_ri_toggle;

   // Rising zero crossing: previous sample negative, current one non-negative.
   assign w_trig = new_sample_ready & r_prev_msb & ~new_sample_in[15];

`ifdef WAVE_CAPTURE_AUTOTRIG_EN
   logic [11:0] r_arm_cnt;

   // Held at zero outside ARMED, so every entry to ARMED starts a fresh count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_arm_cnt <= 12'd0;
      else if (r_state != ARMED)
         r_arm_cnt <= 12'd0;
      else if (new_sample_ready)
         r_arm_cnt <= r_arm_cnt + 12'd1;
   end

   assign w_arm_fire = w_trig | (new_sample_ready & (r_arm_cnt == 12'hFFF));
`else
   assign w_arm_fire = w_trig;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_state <= ARMED;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ARMED:   if (w_arm_fire) w_state_nxt = ACTIVE;
         ACTIVE:  if (new_sample_ready && r_count == 8'hFF) w_state_nxt = WAIT;
         WAIT:    if (wave_display_idle) w_state_nxt = ARMED;
         default: w_state_nxt = ARMED;
      endcase
   end

   always_comb begin
      w_wr_en     = 1'b0;
      w_wr_cnt    = r_count;
      w_prev_upd  = 1'b0;
      w_ri_toggle = 1'b0;
      case (r_state)
         ARMED: begin
            w_wr_en    = w_arm_fire;
            w_wr_cnt   = 8'h00;
            w_prev_upd = new_sample_ready;
         end
         ACTIVE: begin
            w_wr_en    = new_sample_ready;
            w_prev_upd = new_sample_ready;
         end
         WAIT:    w_ri_toggle = wave_display_idle;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count      <= 8'h00;
         r_prev_msb   <= 1'b0;
         r_read_index <= 1'b0;
      end else begin
         if (w_wr_en)
            r_count <= w_wr_cnt + 8'h01;
         if (w_prev_upd)
            r_prev_msb <= new_sample_in[15];
         if (w_ri_toggle)
            r_read_index <= ~r_read_index;
      end
   end

   // Address uses the pre-toggle read_index so writes always land in the back half.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_en     <= 1'b0;
         r_wr_addr   <= 9'h000;
         r_wr_sample <= 8'h00;
      end else begin
         r_wr_en <= w_wr_en;
         if (w_wr_en) begin
            r_wr_addr   <= {~r_read_index, w_wr_cnt};
            r_wr_sample <= {~new_sample_in[15], new_sample_in[14:8]};
         end
      end
   end

   assign write_enable  = r_wr_en;
   assign write_address = r_wr_addr;
   assign write_sample  = r_wr_sample;
   assign read_index    = r_read_index;

endmodule

// File: tb/tb_wave_capture.sv
// Directed self-checking bench for wave_capture.
module tb_wave_capture;

   logic        clk;
   logic        reset;
   logic        new_sample_ready;
   logic [15:0] new_sample_in;
   logic        wave_display_idle;
   logic [8:0]  write_address;
   logic        write_enable;
   logic [7:0]  write_sample;
   logic        read_index;

   int n_vec = 0;
   int n_err = 0;

   wave_capture dut (
      .clk               (clk),
      .reset             (reset),
      .new_sample_ready  (new_sample_ready),
      .new_sample_in     (new_sample_in),
      .wave_display_idle (wave_display_idle),
      .write_address     (write_address),
      .write_enable      (write_enable),
      .write_sample      (write_sample),
      .read_index        (read_index)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs, then land 1ns after the edge that registers them.
   task automatic step(input logic rdy, input logic [15:0] d, input logic idle);
      new_sample_ready  = rdy;
      new_sample_in     = d;
      wave_display_idle = idle;
      @(posedge clk);
      #1;
      new_sample_ready  = 1'b0;
      wave_display_idle = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      new_sample_ready = 1'b0;
      new_sample_in = 16'h0000;
      wave_display_idle = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_vec++; if (write_enable !== 1'b0) begin n_err++; $display("FAIL reset_we got=%b exp=0", write_enable); end
      n_vec++; if (write_address !== 9'h000) begin n_err++; $display("FAIL reset_addr got=%h exp=000", write_address); end
      n_vec++; if (write_sample !== 8'h00) begin n_err++; $display("FAIL reset_sample got=%h exp=00", write_sample); end
      n_vec++; if (read_index !== 1'b0) begin n_err++; $display("FAIL reset_ri got=%b exp=0", read_index); end
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // First post-reset sample cannot trigger, and a falling crossing never does.
   task automatic test_falling();
      step(1'b1, 16'h0100, 1'b0);
      n_vec++; if (write_enable !== 1'b0) begin n_err++; $display("FAIL first_sample_we got=%b exp=0", write_enable); end
      step(1'b1, 16'hFF00, 1'b0);
      n_vec++; if (write_enable !== 1'b0) begin n_err++; $display("FAIL falling_we got=%b exp=0", write_enable); end
      step(1'b1, 16'hFF00, 1'b0);
      n_vec++; if (write_enable !== 1'b0) begin n_err++; $display("FAIL neg_hold_we got=%b exp=0", write_enable); end
   endtask

   // Full 256-write capture with back-to-back strobes; idle pulses mid-capture must be ignored.
   task automatic test_capture(input logic [8:0] base, input logic ri);
      logic [7:0] exp_s;
      step(1'b1, 16'hFF00, 1'b0);
      n_vec++; if (write_enable !== 1'b0) begin n_err++; $display("FAIL pre_trig_we got=%b exp=0", write_enable); end
      step(1'b1, 16'h0100, 1'b0);
      n_vec++;
      if ({write_enable, write_address, write_sample} !== {1'b1, base, 8'h81}) begin
         n_err++;
         $display("FAIL trig_write got we=%b addr=%h s=%h exp we=1 addr=%h s=81",
                  write_enable, write_address, write_sample, base);
      end
      for (int i = 1; i < 256; i++) begin
         exp_s = 8'(i) ^ 8'h80;
         step(1'b1, {8'(i), 8'h00}, (i % 17) == 0);
         n_vec++;
         if ({write_enable, write_address, write_sample} !== {1'b1, 9'(base + 9'(i)), exp_s}) begin
            n_err++;
            $display("FAIL cap_write[%0d] got we=%b addr=%h s=%h exp we=1 addr=%h s=%h",
                     i, write_enable, write_address, write_sample, 9'(base + 9'(i)), exp_s);
         end
      end
      step(1'b1, 16'h0100, 1'b0);
      n_vec++; if (write_enable !== 1'b0) begin n_err++; $display("FAIL strobe_257_we got=%b exp=0", write_enable); end
      n_vec++; if (read_index !== ri) begin n_err++; $display("FAIL ri_during_cap got=%b exp=%b", read_index, ri); end
   endtask

   task automatic test_wait_swap(input logic ri_old);
      step(1'b1, 16'hFF00, 1'b0);
      n_vec++; if (write_enable !== 1'b0) begin n_err++; $display("FAIL wait_neg_we got=%b exp=0", write_enable); end
      step(1'b1, 16'h0100, 1'b0);
      n_vec++; if (write_enable !== 1'b0) begin n_err++; $display("FAIL wait_cross_we got=%b exp=0", write_enable); end
      step(1'b0, 16'h0000, 1'b1);
      n_vec++; if (read_index !== ~ri_old) begin n_err++; $display("FAIL swap_ri got=%b exp=%b", read_index, ~ri_old); end
      n_vec++; if (write_enable !== 1'b0) begin n_err++; $display("FAIL swap_we got=%b exp=0", write_enable); end
      step(1'b0, 16'h0000, 1'b1);
      n_vec++; if (read_index !== ~ri_old) begin n_err++; $display("FAIL armed_idle_ri got=%b exp=%b", read_index, ~ri_old); end
   endtask

   task automatic test_reset_mid_active();
      reset = 1'b0;
      #2;
      reset = 1'b1;
      @(posedge clk);
      #1;
      step(1'b1, 16'hFF00, 1'b0);
      step(1'b1, 16'h0100, 1'b0);
      n_vec++; if ({write_enable, write_address} !== {1'b1, 9'h100}) begin n_err++; $display("FAIL mid_trig got we=%b addr=%h exp we=1 addr=100", write_enable, write_address); end
      for (int i = 1; i < 10; i++) step(1'b1, 16'h2200, 1'b0);
      n_vec++; if ({write_enable, write_address, write_sample} !== {1'b1, 9'h109, 8'hA2}) begin
         n_err++; $display("FAIL mid_10th got we=%b addr=%h s=%h exp we=1 addr=109 s=a2", write_enable, write_address, write_sample);
      end
      #2;
      reset = 1'b0;
      #1;
      n_vec++; if (write_enable !== 1'b0) begin n_err++; $display("FAIL async_we got=%b exp=0", write_enable); end
      n_vec++; if (write_address !== 9'h000) begin n_err++; $display("FAIL async_addr got=%h exp=000", write_address); end
      n_vec++; if (write_sample !== 8'h00) begin n_err++; $display("FAIL async_sample got=%h exp=00", write_sample); end
      n_vec++; if (read_index !== 1'b0) begin n_err++; $display("FAIL async_ri got=%b exp=0", read_index); end
      @(posedge clk);
      #2;
      reset = 1'b1;
      @(posedge clk);
      #1;
      step(1'b1, 16'h0100, 1'b0);
      n_vec++; if (write_enable !== 1'b0) begin n_err++; $display("FAIL post_rst1_we got=%b exp=0", write_enable); end
      step(1'b1, 16'h0100, 1'b0);
      n_vec++; if (write_enable !== 1'b0) begin n_err++; $display("FAIL post_rst2_we got=%b exp=0", write_enable); end
   endtask

   task automatic test_autotrig();
      int writes;
      int first;
      logic [8:0] first_addr;
      logic [7:0] first_s;
      writes = 0;
      first = -1;
      first_addr = 9'h000;
      first_s = 8'h00;
      reset = 1'b0;
      #2;
      reset = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 1; i <= 5000; i++) begin
         step(1'b1, 16'h1000, 1'b0);
         if (write_enable === 1'b1) begin
            if (first < 0) begin
               first = i;
               first_addr = write_address;
               first_s = write_sample;
            end
            writes++;
         end
      end
`ifdef WAVE_CAPTURE_AUTOTRIG_EN
      n_vec++; if (first !== 4096) begin n_err++; $display("FAIL auto_first got=%0d exp=4096", first); end
      n_vec++; if (writes !== 256) begin n_err++; $display("FAIL auto_writes got=%0d exp=256", writes); end
      n_vec++; if ({first_addr, first_s} !== {9'h100, 8'h90}) begin n_err++; $display("FAIL auto_data got addr=%h s=%h exp addr=100 s=90", first_addr, first_s); end
`else
      n_vec++; if (writes !== 0) begin n_err++; $display("FAIL no_auto_writes got=%0d exp=0", writes); end
      n_vec++; if (first !== -1) begin n_err++; $display("FAIL no_auto_first got=%0d exp=-1", first); end
`endif
   endtask

   initial begin
      test_reset();
      test_falling();
      test_capture(9'h100, 1'b0);
      test_wait_swap(1'b0);
      test_capture(9'h000, 1'b1);
      test_wait_swap(1'b1);
      test_reset_mid_active();
      test_autotrig();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/wave_capture.md
WAVE_CAPTURE -- requirements
Module: wave_capture

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-003 new_sample_ready  input  1  one-cycle strobe; new_sample_in is valid this cycle.
REQ-004 new_sample_in  input  16  signed two's-complement audio sample.
REQ-005 wave_display_idle  input  1  high while the display is outside its active drawing region, so the buffer may be swapped.
REQ-006 write_address  output  9  RAM write address, formed as {~read_index, sample_count[7:0]}.
REQ-007 write_enable  output  1  one-cycle RAM write strobe.
REQ-008 write_sample  output  8  unsigned offset-binary sample = new_sample_in[15:8] with bit 7 inverted.
REQ-009 read_index  output  1  selects the RAM half the display reads; capture writes the other half.

Function
REQ-010 FSM states SHALL be ARMED, ACTIVE and WAIT, binary-encoded in a state register.
REQ-011 The block SHALL store prev_msb, which is new_sample_in[15] at the last new_sample_ready.
REQ-012 Trigger SHALL mean new_sample_ready=1, prev_msb=1 and new_sample_in[15]=0, i.e. a rising zero crossing.
REQ-013 In ARMED on trigger, the triggering sample SHALL be written at count 0, count SHALL become 1, and the FSM SHALL go to ACTIVE.
REQ-014 In ARMED without trigger, the block SHALL issue no write and update only prev_msb on each strobe.
REQ-015 In ACTIVE, each new_sample_ready SHALL write the sample at the current count, then increment the 8-bit count.
REQ-016 The write at count 255 SHALL be the last one; count SHALL then wrap to 0 and the FSM SHALL go to WAIT, giving exactly 256 writes per capture.
REQ-017 In WAIT, new_sample_ready SHALL be ignored: no write, and prev_msb is not updated.
REQ-018 In WAIT, when wave_display_idle=1, read_index SHALL toggle on that edge and the FSM SHALL go to ARMED.
REQ-019 wave_display_idle SHALL be ignored in ARMED and ACTIVE.
REQ-020 Write outputs SHALL be registered: write_enable, write_address and write_sample are valid exactly 1 cycle after the accepting strobe.
REQ-021 write_enable SHALL be high for exactly one cycle per accepted sample and low otherwise.
REQ-022 write_address SHALL use read_index as it was at the strobe cycle, so writes never target the half the display is reading.
REQ-023 Back-to-back strobes on consecutive cycles SHALL each be accepted.
REQ-024 When a strobe coincides with the ACTIVE to WAIT transition, it SHALL be the count-255 write; a strobe in the following cycle is dropped.

Reset
REQ-025 While reset=0, the block SHALL hold: state=ARMED, count=0, read_index=0, prev_msb=0, write_enable=0, write_address=0, write_sample=0.
REQ-026 Reset asserted mid-ACTIVE SHALL abort the capture with no further writes; the partially written half is left undefined.
REQ-027 Because prev_msb=0 after reset, the first post-reset sample SHALL NOT trigger.

Configuration
REQ-028 With WAVE_CAPTURE_AUTOTRIG_EN defined, a 12-bit counter SHALL count strobes received in ARMED, cleared on entry to ARMED and on reset.
REQ-029 With WAVE_CAPTURE_AUTOTRIG_EN defined, the 4096th strobe in ARMED with no trigger SHALL be treated as a trigger.
REQ-030 Without WAVE_CAPTURE_AUTOTRIG_EN, the counter SHALL be absent and ARMED exits only on a true zero crossing.

Verification
REQ-031 Strobes with samples 0xFF00 then 0x0100 from ARMED -> one cycle later write_enable=1, write_address=0x100, write_sample=0x81, state=ACTIVE.
REQ-032 Trigger followed by 255 more strobes -> exactly 256 writes at addresses 0x100..0x1FF, then state=WAIT; a 257th strobe produces no write.
REQ-033 In WAIT, pulse wave_display_idle -> read_index 0->1, state=ARMED; the next capture writes 0x000..0x0FF.
REQ-034 Drive reset=0 after 10 writes in ACTIVE -> outputs zero immediately (asynchronous), read_index=0, state=ARMED, no writes until a new crossing.
REQ-035 Only positive samples (0x1000) for 5000 strobes -> with WAVE_CAPTURE_AUTOTRIG_EN, the first write appears after strobe 4096; without it, no write.
REQ-036 Samples 0x0100 then 0xFF00 (falling crossing) in ARMED -> no write, state stays ARMED.
